// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: forwarding select codes, hazard FSM states and
// the register-match helper used by the forwarding comparators.
package riscv_pipe_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  // x0 is hard-wired to zero, so a write to it never produces a forwardable value.
  function automatic logic reg_hit(input logic we, input logic [4:0] rd, input logic [4:0] src);
    return we && (rd != REG_X0) && (rd == src);
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding select for one EX source register; the younger
// EX/MEM result takes priority over MEM/WB.
module fwd_unit
  import riscv_pipe_pkg::*;
(
  input  logic [4:0] i_src,
  input  logic [4:0] i_ex_mem_rd,
  input  logic       i_ex_mem_we,
  input  logic [4:0] i_mem_wb_rd,
  input  logic       i_mem_wb_we,
  output logic [1:0] o_sel
);

  always_comb begin
    o_sel = FWD_REG;
    if (reg_hit(i_ex_mem_we, i_ex_mem_rd, i_src)) begin
      o_sel = FWD_MEM;
    end else if (reg_hit(i_mem_wb_we, i_mem_wb_rd, i_src)) begin
      o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage RV32I pipeline: memory-wait FSM
// with timeout, redirect and load-use hazard priority, forwarding selects, perf counters.
module pipe_hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IF_ID_rs1,
  input  logic [4:0]       IF_ID_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ID_EX_rs1,
  input  logic [4:0]       ID_EX_rs2,
  input  logic [4:0]       ID_EX_rd,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       EX_MEM_rd,
  input  logic             EX_MEM_RegWrite,
  input  logic [4:0]       MEM_WB_rd,
  input  logic             MEM_WB_RegWrite,
  input  logic             ex_redirect,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             IF_ID_en,
  output logic             ID_EX_en,
  output logic             EX_MEM_en,
  output logic             MEM_WB_en,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             MEM_WB_flush,
  output logic             pc_sel_redirect,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_t              r_state;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic                r_err;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic [CNT_W-1:0]    r_flush_cnt;

  logic       w_wait_last;
  logic       w_timeout;
  logic       w_mem_stall;
  logic       w_load_use;
  logic       w_redirect;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  assign w_wait_last = (r_state == MEM_WAIT) && (r_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
  assign w_timeout   = w_wait_last && !dmem_ready;
  // The timeout cycle is a forced release: the memory stall is dropped for one cycle.
  assign w_mem_stall = dmem_req && !dmem_ready && !w_timeout;
  assign w_load_use  = ID_EX_MemRead && (ID_EX_rd != REG_X0) &&
                       ((id_use_rs1 && (IF_ID_rs1 == ID_EX_rd)) ||
                        (id_use_rs2 && (IF_ID_rs2 == ID_EX_rd)));
  assign w_redirect  = !rst && !w_mem_stall && ex_redirect;

  fwd_unit u_fwd_a (
    .i_src       (ID_EX_rs1),
    .i_ex_mem_rd (EX_MEM_rd),
    .i_ex_mem_we (EX_MEM_RegWrite),
    .i_mem_wb_rd (MEM_WB_rd),
    .i_mem_wb_we (MEM_WB_RegWrite),
    .o_sel       (w_fwd_a)
  );

  fwd_unit u_fwd_b (
    .i_src       (ID_EX_rs2),
    .i_ex_mem_rd (EX_MEM_rd),
    .i_ex_mem_we (EX_MEM_RegWrite),
    .i_mem_wb_rd (MEM_WB_rd),
    .i_mem_wb_we (MEM_WB_RegWrite),
    .o_sel       (w_fwd_b)
  );

  always_comb begin
    pc_en           = 1'b1;
    IF_ID_en        = 1'b1;
    ID_EX_en        = 1'b1;
    EX_MEM_en       = 1'b1;
    MEM_WB_en       = 1'b1;
    IF_ID_flush     = 1'b0;
    ID_EX_flush     = 1'b0;
    MEM_WB_flush    = 1'b0;
    pc_sel_redirect = 1'b0;
    fwd_a           = FWD_REG;
    fwd_b           = FWD_REG;
    if (!rst) begin
      fwd_a = w_fwd_a;
      fwd_b = w_fwd_b;
      if (w_mem_stall) begin
        pc_en        = 1'b0;
        IF_ID_en     = 1'b0;
        ID_EX_en     = 1'b0;
        EX_MEM_en    = 1'b0;
        MEM_WB_flush = 1'b1;
      end else if (ex_redirect) begin
        pc_sel_redirect = 1'b1;
        IF_ID_flush     = 1'b1;
        ID_EX_flush     = 1'b1;
      end else if (w_load_use) begin
        pc_en       = 1'b0;
        IF_ID_en    = 1'b0;
        ID_EX_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_wait_cnt  <= '0;
      r_err       <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (r_state == RUN) begin
        if (dmem_req && !dmem_ready) begin
          r_state <= MEM_WAIT;
        end
      end else if (dmem_ready || w_wait_last) begin
        r_state    <= RUN;
        r_wait_cnt <= '0;
      end else begin
        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
      if (!pc_en) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_redirect) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign mem_timeout_err = r_err;
  assign stall_cnt       = r_stall_cnt;
  assign flush_cnt       = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed vector table, multi-cycle
// corner sequences and a randomized run against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned TO = 8;
  localparam int unsigned CW = 8;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] IF_ID_rs1, IF_ID_rs2, ID_EX_rs1, ID_EX_rs2, ID_EX_rd, EX_MEM_rd, MEM_WB_rd;
  logic id_use_rs1, id_use_rs2, ID_EX_MemRead, EX_MEM_RegWrite, MEM_WB_RegWrite;
  logic ex_redirect, dmem_req, dmem_ready;
  logic pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en;
  logic IF_ID_flush, ID_EX_flush, MEM_WB_flush, pc_sel_redirect, mem_timeout_err;
  logic [1:0] fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2), .ID_EX_rd(ID_EX_rd),
    .ID_EX_MemRead(ID_EX_MemRead),
    .EX_MEM_rd(EX_MEM_rd), .EX_MEM_RegWrite(EX_MEM_RegWrite),
    .MEM_WB_rd(MEM_WB_rd), .MEM_WB_RegWrite(MEM_WB_RegWrite),
    .ex_redirect(ex_redirect), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .IF_ID_en(IF_ID_en), .ID_EX_en(ID_EX_en),
    .EX_MEM_en(EX_MEM_en), .MEM_WB_en(MEM_WB_en),
    .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush), .MEM_WB_flush(MEM_WB_flush),
    .pc_sel_redirect(pc_sel_redirect), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_timeout_err(mem_timeout_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  wire [4:0] act_en = {pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en};
  wire [2:0] act_fl = {IF_ID_flush, ID_EX_flush, MEM_WB_flush};

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    string      name;
    logic [4:0] if_rs1, if_rs2;
    logic       use1, use2;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic       memread;
    logic [4:0] em_rd;
    logic       em_rw;
    logic [4:0] mw_rd;
    logic       mw_rw;
    logic       redir, req, rdy;
    logic [4:0] exp_en;
    logic [2:0] exp_fl;
    logic       exp_psel;
    logic [1:0] exp_fa, exp_fb;
  } vec_t;

  vec_t vt[12];

  task automatic drive_idle();
    IF_ID_rs1 = '0; IF_ID_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ID_EX_rs1 = '0; ID_EX_rs2 = '0; ID_EX_rd = '0; ID_EX_MemRead = 1'b0;
    EX_MEM_rd = '0; EX_MEM_RegWrite = 1'b0; MEM_WB_rd = '0; MEM_WB_RegWrite = 1'b0;
    ex_redirect = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v);
    IF_ID_rs1 = v.if_rs1; IF_ID_rs2 = v.if_rs2; id_use_rs1 = v.use1; id_use_rs2 = v.use2;
    ID_EX_rs1 = v.ex_rs1; ID_EX_rs2 = v.ex_rs2; ID_EX_rd = v.ex_rd; ID_EX_MemRead = v.memread;
    EX_MEM_rd = v.em_rd; EX_MEM_RegWrite = v.em_rw; MEM_WB_rd = v.mw_rd; MEM_WB_RegWrite = v.mw_rw;
    ex_redirect = v.redir; dmem_req = v.req; dmem_ready = v.rdy;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_load_use();
    IF_ID_rs1 = 5'd5; id_use_rs1 = 1'b1; IF_ID_rs2 = 5'd1; id_use_rs2 = 1'b1;
    ID_EX_rd = 5'd5; ID_EX_MemRead = 1'b1;
  endtask

  // Reference model: pipeline view of the memory wait as "cycles spent waiting".
  bit m_in_wait, m_err;
  int m_waited, m_stall, m_flush;
  logic [4:0] e_en;
  logic [2:0] e_fl;
  logic       e_psel;
  logic [1:0] e_fa, e_fb;

  function automatic logic [1:0] ref_fwd(input logic [4:0] src);
    if (EX_MEM_RegWrite && EX_MEM_rd != 0 && EX_MEM_rd == src) return 2'b10;
    if (MEM_WB_RegWrite && MEM_WB_rd != 0 && MEM_WB_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_eval();
    bit released, stalled, lu;
    released = m_in_wait && (m_waited == TO - 1) && !dmem_ready;
    stalled  = dmem_req && !dmem_ready && !released;
    lu = ID_EX_MemRead && ID_EX_rd != 0 &&
         ((id_use_rs1 && IF_ID_rs1 == ID_EX_rd) || (id_use_rs2 && IF_ID_rs2 == ID_EX_rd));
    e_en = 5'b11111; e_fl = 3'b000; e_psel = 1'b0; e_fa = 2'b00; e_fb = 2'b00;
    if (!rst) begin
      e_fa = ref_fwd(ID_EX_rs1);
      e_fb = ref_fwd(ID_EX_rs2);
      if (stalled) begin
        e_en = 5'b00001; e_fl = 3'b001;
      end else if (ex_redirect) begin
        e_psel = 1'b1; e_fl = 3'b110;
      end else if (lu) begin
        e_en = 5'b00111; e_fl = 3'b010;
      end
    end
  endtask

  task automatic model_advance();
    if (rst) begin
      m_in_wait = 0; m_err = 0; m_waited = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!e_en[4]) m_stall++;
      if (e_psel) m_flush++;
      if (m_in_wait) begin
        if (dmem_ready || m_waited == TO - 1) begin
          if (!dmem_ready) m_err = 1;
          m_in_wait = 0;
          m_waited = 0;
        end else begin
          m_waited++;
        end
      end else if (dmem_req && !dmem_ready) begin
        m_in_wait = 1;
        m_waited = 0;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();

    //                 name            ifr1 ifr2 u1 u2 exr1 exr2 exrd mr  emrd emw mwrd mww rd rq ry  en        fl      ps fa     fb
    vt[0]  = '{"idle",              0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 3'b000, 0, 2'b00, 2'b00};
    vt[1]  = '{"loaduse_rs1",       5, 1, 1, 1, 2, 3, 5, 1, 0, 0, 0, 0, 0, 0, 0, 5'b00111, 3'b010, 0, 2'b00, 2'b00};
    vt[2]  = '{"fwd_mem_prio",      0, 0, 0, 0, 7, 0, 0, 0, 7, 1, 7, 1, 0, 0, 0, 5'b11111, 3'b000, 0, 2'b10, 2'b00};
    vt[3]  = '{"fwd_x0_wb",         0, 0, 0, 0, 4, 0, 0, 0, 4, 0, 0, 1, 0, 0, 0, 5'b11111, 3'b000, 0, 2'b00, 2'b00};
    vt[4]  = '{"fwd_wb_both",       0, 0, 0, 0, 9, 9, 0, 0, 9, 0, 9, 1, 0, 0, 0, 5'b11111, 3'b000, 0, 2'b01, 2'b01};
    vt[5]  = '{"redirect_over_lu",  5, 1, 1, 1, 0, 0, 5, 1, 0, 0, 0, 0, 1, 0, 0, 5'b11111, 3'b110, 1, 2'b00, 2'b00};
    vt[6]  = '{"memstall_over_all", 5, 1, 1, 1, 0, 0, 5, 1, 0, 0, 0, 0, 1, 1, 0, 5'b00001, 3'b001, 0, 2'b00, 2'b00};
    vt[7]  = '{"lu_rd_x0",          0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 3'b000, 0, 2'b00, 2'b00};
    vt[8]  = '{"lu_rs2_unused",     1, 6, 1, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 3'b000, 0, 2'b00, 2'b00};
    vt[9]  = '{"lu_rs2",            1, 6, 1, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0, 5'b00111, 3'b010, 0, 2'b00, 2'b00};
    vt[10] = '{"lu_not_load",       6, 0, 1, 0, 0, 0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 3'b000, 0, 2'b00, 2'b00};
    vt[11] = '{"mem_ready_lu",      5, 1, 1, 1, 3, 8, 5, 1, 3, 1, 8, 1, 0, 1, 1, 5'b00111, 3'b010, 0, 2'b10, 2'b01};

    // Reset state, with hazards present on the inputs.
    @(negedge clk);
    set_load_use(); ex_redirect = 1'b1; ID_EX_rs1 = 5'd3; EX_MEM_rd = 5'd3; EX_MEM_RegWrite = 1'b1;
    dmem_req = 1'b1;
    #1;
    chk("rst_en", 32'(act_en), 32'h1f);
    chk("rst_fl", 32'(act_fl), 32'h0);
    chk("rst_psel", 32'(pc_sel_redirect), 32'h0);
    chk("rst_fwd_a", 32'(fwd_a), 32'h0);
    @(negedge clk);
    #1;
    chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
    chk("rst_flush_cnt", 32'(flush_cnt), 32'h0);
    chk("rst_err", 32'(mem_timeout_err), 32'h0);

    for (int i = 0; i < 12; i++) begin
      do_reset();
      apply_vec(vt[i]);
      #1;
      chk({vt[i].name, "_en"}, 32'(act_en), 32'(vt[i].exp_en));
      chk({vt[i].name, "_fl"}, 32'(act_fl), 32'(vt[i].exp_fl));
      chk({vt[i].name, "_psel"}, 32'(pc_sel_redirect), 32'(vt[i].exp_psel));
      chk({vt[i].name, "_fwd_a"}, 32'(fwd_a), 32'(vt[i].exp_fa));
      chk({vt[i].name, "_fwd_b"}, 32'(fwd_b), 32'(vt[i].exp_fb));
    end

    // Load-use: one bubble, then the load result is picked up from MEM/WB.
    do_reset();
    set_load_use();
    #1;
    chk("lu1_en", 32'(act_en), 32'h07);
    chk("lu1_fl", 32'(act_fl), 32'h2);
    @(negedge clk);
    drive_idle();
    ID_EX_rs1 = 5'd5; MEM_WB_rd = 5'd5; MEM_WB_RegWrite = 1'b1;
    #1;
    chk("lu2_fwd_a", 32'(fwd_a), 32'h1);
    chk("lu2_en", 32'(act_en), 32'h1f);
    chk("lu2_stall_cnt", 32'(stall_cnt), 32'h1);

    // Memory wait of three cycles, then completion.
    do_reset();
    dmem_req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("mw_en", 32'(act_en), 32'h01);
      chk("mw_fl", 32'(act_fl), 32'h1);
      @(negedge clk);
    end
    dmem_ready = 1'b1;
    #1;
    chk("mw_ready_en", 32'(act_en), 32'h1f);
    chk("mw_ready_fl", 32'(act_fl), 32'h0);
    chk("mw_stall_cnt", 32'(stall_cnt), 32'h3);
    @(negedge clk);
    drive_idle();
    #1;
    chk("mw_after_stall_cnt", 32'(stall_cnt), 32'h3);
    chk("mw_after_en", 32'(act_en), 32'h1f);

    // Redirect beats a simultaneous load-use.
    do_reset();
    set_load_use();
    ex_redirect = 1'b1;
    #1;
    chk("rd_psel", 32'(pc_sel_redirect), 32'h1);
    chk("rd_fl", 32'(act_fl), 32'h6);
    chk("rd_en", 32'(act_en), 32'h1f);
    @(negedge clk);
    drive_idle();
    #1;
    chk("rd_flush_cnt", 32'(flush_cnt), 32'h1);
    chk("rd_stall_cnt", 32'(stall_cnt), 32'h0);

    // Timeout: TO stalled cycles, forced release, sticky error.
    do_reset();
    dmem_req = 1'b1;
    for (int c = 0; c < TO; c++) begin
      #1;
      chk("to_wait_pc_en", 32'(pc_en), 32'h0);
      chk("to_wait_err", 32'(mem_timeout_err), 32'h0);
      @(negedge clk);
    end
    #1;
    chk("to_release_en", 32'(act_en), 32'h1f);
    chk("to_release_fl", 32'(act_fl), 32'h0);
    @(negedge clk);
    #1;
    chk("to_err_set", 32'(mem_timeout_err), 32'h1);
    chk("to_restall_pc_en", 32'(pc_en), 32'h0);
    chk("to_stall_cnt", 32'(stall_cnt), 32'(TO));
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      dmem_ready = (c == 5);
      #1;
      chk("to_err_sticky", 32'(mem_timeout_err), 32'h1);
    end

    // Reset while waiting on memory: back to RUN with a fresh wait count.
    @(negedge clk);
    dmem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    ID_EX_rs1 = 5'd3; EX_MEM_rd = 5'd3; EX_MEM_RegWrite = 1'b1;
    #1;
    chk("rstw_en", 32'(act_en), 32'h1f);
    chk("rstw_fl", 32'(act_fl), 32'h0);
    chk("rstw_fwd_a", 32'(fwd_a), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstw_err", 32'(mem_timeout_err), 32'h0);
    chk("rstw_stall_cnt", 32'(stall_cnt), 32'h0);
    chk("rstw_flush_cnt", 32'(flush_cnt), 32'h0);
    chk("rstw_fwd_a_after", 32'(fwd_a), 32'h2);
    for (int c = 0; c < TO; c++) begin
      #1;
      chk("rstw_wait_pc_en", 32'(pc_en), 32'h0);
      @(negedge clk);
    end
    #1;
    chk("rstw_release_pc_en", 32'(pc_en), 32'h1);

    // Randomized run against the reference model.
    do_reset();
    m_in_wait = 0; m_err = 0; m_waited = 0; m_stall = 0; m_flush = 0;
    for (int ph = 0; ph < 4; ph++) begin
      for (int n = 0; n < 750; n++) begin
        IF_ID_rs1 = 5'($urandom_range(0, 7)); IF_ID_rs2 = 5'($urandom_range(0, 7));
        id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom);
        ID_EX_rs1 = 5'($urandom_range(0, 7)); ID_EX_rs2 = 5'($urandom_range(0, 7));
        ID_EX_rd = 5'($urandom_range(0, 7)); ID_EX_MemRead = 1'($urandom);
        EX_MEM_rd = 5'($urandom_range(0, 7)); EX_MEM_RegWrite = 1'($urandom);
        MEM_WB_rd = 5'($urandom_range(0, 7)); MEM_WB_RegWrite = 1'($urandom);
        ex_redirect = ($urandom_range(0, 3) == 0);
        dmem_req = ($urandom_range(0, 2) != 0);
        case (ph)
          0: dmem_ready = 1'($urandom);
          1: dmem_ready = ($urandom_range(0, 11) == 0);
          2: dmem_ready = ($urandom_range(0, 3) != 0);
          default: dmem_ready = ($urandom_range(0, 7) == 0);
        endcase
        rst = ($urandom_range(0, 199) == 0);
        #1;
        model_eval();
        chk("rnd_en", 32'(act_en), 32'(e_en));
        chk("rnd_fl", 32'(act_fl), 32'(e_fl));
        chk("rnd_psel", 32'(pc_sel_redirect), 32'(e_psel));
        chk("rnd_fwd_a", 32'(fwd_a), 32'(e_fa));
        chk("rnd_fwd_b", 32'(fwd_b), 32'(e_fb));
        chk("rnd_err", 32'(mem_timeout_err), 32'(m_err));
        chk("rnd_stall_cnt", 32'(stall_cnt), 32'(m_stall % 256));
        chk("rnd_flush_cnt", 32'(flush_cnt), 32'(m_flush % 256));
        model_advance();
        @(negedge clk);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
